// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_EALU = 2'b01;
    localparam logic [1:0] FWD_MALU = 2'b10;
    localparam logic [1:0] FWD_MMO  = 2'b11;

    // Wide enough for the largest legal memory timeout.
    localparam int WCNT_W = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        FAULT = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: hazard inputs and stage controls.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_branch_taken;
    logic             ewreg;
    logic             em2reg;
    logic [4:0]       ern;
    logic             mwreg;
    logic             mm2reg;
    logic [4:0]       mrn;
    logic             m_memreq;
    logic             m_memack;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_we;
    logic             memwb_bubble;
    logic             mem_fault;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_branch_taken,
               ewreg, em2reg, ern, mwreg, mm2reg, mrn, m_memreq, m_memack,
        input  fwda, fwdb, pc_we, ifid_we, ifid_flush, idex_bubble,
               exmem_we, memwb_bubble, mem_fault, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_branch_taken,
               ewreg, em2reg, ern, mwreg, mm2reg, mrn, m_memreq, m_memack,
        output fwda, fwdb, pc_we, ifid_we, ifid_flush, idex_bubble,
               exmem_we, memwb_bubble, mem_fault, stall_cycles
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Single-operand forwarding select for the ID stage; EX results beat MEM results.
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic       use_src,
    input  logic [4:0] src,
    input  logic       ewreg,
    input  logic       em2reg,
    input  logic [4:0] ern,
    input  logic       mwreg,
    input  logic       mm2reg,
    input  logic [4:0] mrn,
    output logic [1:0] sel
);

    // An EX-stage load never forwards here: its data is not ready, the load-use stall handles it.
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        sel = FWD_RF;
        if (use_src) begin
            if (ewreg && (ern != 5'd0) && (ern == src) && !em2reg) begin
                sel = FWD_EALU;
            end else if (mwreg && (mrn != 5'd0) && (mrn == src)) begin
                sel = mm2reg ? FWD_MMO : FWD_MALU;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller: forwarding selects, load-use/branch/memory-wait stalls, timeout fault.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic              clock,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus
);

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                mem_fault_q, mem_fault_d;
    logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;

    logic                mstall;
    logic                mem_done;
    logic                luh;
    logic [1:0]          fwda_raw, fwdb_raw;

    pipe_fwd_unit u_fwd_rs (
        .use_src (bus.id_use_rs),
        .src     (bus.id_rs),
        .ewreg   (bus.ewreg),
        .em2reg  (bus.em2reg),
        .ern     (bus.ern),
        .mwreg   (bus.mwreg),
        .mm2reg  (bus.mm2reg),
        .mrn     (bus.mrn),
        .sel     (fwda_raw)
    );

    pipe_fwd_unit u_fwd_rt (
        .use_src (bus.id_use_rt),
        .src     (bus.id_rt),
        .ewreg   (bus.ewreg),
        .em2reg  (bus.em2reg),
        .ern     (bus.ern),
        .mwreg   (bus.mwreg),
        .mm2reg  (bus.mm2reg),
        .mrn     (bus.mrn),
        .sel     (fwdb_raw)
    );

    assign luh = bus.ewreg && bus.em2reg && (bus.ern != 5'd0) &&
                 ((bus.id_use_rs && (bus.ern == bus.id_rs)) ||
                  (bus.id_use_rt && (bus.ern == bus.id_rt)));

    // A withdrawn request in MWAIT ends the wait just like an ack.
    assign mem_done = bus.m_memack || !bus.m_memreq;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        mstall  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.m_memreq && !bus.m_memack) begin
                    mstall  = 1'b1;
                    state_d = MWAIT;
                    wcnt_d  = WCNT_W'(1);
                end
            end
            MWAIT: begin
                if (mem_done) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == WCNT_W'(MEM_TIMEOUT)) begin
                    state_d = FAULT;
                    mstall  = 1'b1;
                end else begin
                    wcnt_d  = wcnt_q + 1'b1;
                    mstall  = 1'b1;
                end
            end
            FAULT:   mstall  = 1'b1;
            default: state_d = RUN;
        endcase
        mem_fault_d = mem_fault_q || (state_d == FAULT);
    end

    // ID/EX has no separate hold: it follows exmem_we, so a memory stall freezes it without a bubble.
    always_comb begin
        bus.pc_we        = 1'b1;
        bus.ifid_we      = 1'b1;
        bus.ifid_flush   = 1'b0;
        bus.idex_bubble  = 1'b0;
        bus.exmem_we     = 1'b1;
        bus.memwb_bubble = 1'b0;
        if (reset) begin
            bus.pc_we        = 1'b0;
            bus.ifid_we      = 1'b0;
            bus.exmem_we     = 1'b0;
            bus.idex_bubble  = 1'b1;
            bus.memwb_bubble = 1'b1;
        end else if (mstall) begin
            bus.pc_we        = 1'b0;
            bus.ifid_we      = 1'b0;
            bus.exmem_we     = 1'b0;
            bus.memwb_bubble = 1'b1;
        end else if (luh) begin
            bus.pc_we        = 1'b0;
            bus.ifid_we      = 1'b0;
            bus.idex_bubble  = 1'b1;
        end else if (bus.id_branch_taken) begin
            bus.ifid_flush   = 1'b1;
        end
    end

    assign bus.fwda = reset ? FWD_RF : fwda_raw;
    assign bus.fwdb = reset ? FWD_RF : fwdb_raw;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!reset && !bus.pc_we && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= RUN;
            wcnt_q         <= '0;
            mem_fault_q    <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            mem_fault_q    <= mem_fault_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.mem_fault    = mem_fault_q;
    assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: table of single-cycle hazard vectors plus multi-cycle memory-wait sequences.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 32;

    // Control bundle: {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_bubble}
    localparam logic [5:0] C_NORM  = 6'b110010;
    localparam logic [5:0] C_BR    = 6'b111010;
    localparam logic [5:0] C_LUH   = 6'b000110;
    localparam logic [5:0] C_STALL = 6'b000001;
    localparam logic [5:0] C_RST   = 6'b000101;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       br;
        logic       ewreg;
        logic       em2reg;
        logic [4:0] ern;
        logic       mwreg;
        logic       mm2reg;
        logic [4:0] mrn;
        logic [1:0] fwda;
        logic [1:0] fwdb;
        logic [5:0] ctl;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] ctl_now();
        return {bus.pc_we, bus.ifid_we, bus.ifid_flush,
                bus.idex_bubble, bus.exmem_we, bus.memwb_bubble};
    endfunction

    task automatic set_idle();
        bus.id_rs = '0; bus.id_rt = '0; bus.id_use_rs = 0; bus.id_use_rt = 0;
        bus.id_branch_taken = 0; bus.ewreg = 0; bus.em2reg = 0; bus.ern = '0;
        bus.mwreg = 0; bus.mm2reg = 0; bus.mrn = '0; bus.m_memreq = 0; bus.m_memack = 0;
    endtask

    task automatic apply(input vec_t v);
        bus.id_rs = v.rs; bus.id_rt = v.rt; bus.id_use_rs = v.use_rs; bus.id_use_rt = v.use_rt;
        bus.id_branch_taken = v.br; bus.ewreg = v.ewreg; bus.em2reg = v.em2reg; bus.ern = v.ern;
        bus.mwreg = v.mwreg; bus.mm2reg = v.mm2reg; bus.mrn = v.mrn;
        bus.m_memreq = 0; bus.m_memack = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        set_idle();
        #1 check("reset ctl", 32'(ctl_now()), 32'(C_RST));
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post-reset stall_cycles", bus.stall_cycles, 0);
        check("post-reset mem_fault", 32'(bus.mem_fault), 0);
    endtask

    vec_t vecs[14];

    initial begin
        //           rs rt urs urt br ew em2 ern mw mm2 mrn fwda   fwdb   ctl
        vecs[0]  = '{5, 0, 1, 0, 0, 1, 0, 5, 0, 0, 0, 2'b01, 2'b00, C_NORM};
        vecs[1]  = '{0, 7, 0, 1, 0, 0, 0, 0, 1, 1, 7, 2'b00, 2'b11, C_NORM};
        vecs[2]  = '{0, 7, 0, 1, 0, 1, 0, 7, 1, 1, 7, 2'b00, 2'b01, C_NORM};
        vecs[3]  = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, C_NORM};
        vecs[4]  = '{4, 0, 1, 0, 0, 0, 0, 0, 1, 0, 4, 2'b10, 2'b00, C_NORM};
        vecs[5]  = '{5, 5, 0, 0, 0, 1, 0, 5, 1, 0, 5, 2'b00, 2'b00, C_NORM};
        vecs[6]  = '{3, 0, 1, 0, 0, 1, 1, 3, 0, 0, 0, 2'b00, 2'b00, C_LUH};
        vecs[7]  = '{2, 3, 1, 0, 0, 1, 1, 3, 0, 0, 0, 2'b00, 2'b00, C_NORM};
        vecs[8]  = '{0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, C_NORM};
        vecs[9]  = '{1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, C_BR};
        vecs[10] = '{3, 0, 1, 0, 1, 1, 1, 3, 0, 0, 0, 2'b00, 2'b00, C_LUH};
        vecs[11] = '{5, 6, 1, 1, 0, 1, 0, 5, 1, 0, 6, 2'b01, 2'b10, C_NORM};
        vecs[12] = '{8, 3, 1, 1, 0, 1, 1, 3, 1, 0, 8, 2'b10, 2'b00, C_LUH};
        vecs[13] = '{6, 6, 1, 1, 1, 1, 0, 9, 1, 1, 9, 2'b00, 2'b00, C_BR};

        // Reset forces forwarding to the register file even with a live match.
        set_idle();
        bus.ewreg = 1; bus.ern = 5; bus.id_rs = 5; bus.id_use_rs = 1;
        #1;
        check("reset fwda", 32'(bus.fwda), 0);
        check("reset ctl initial", 32'(ctl_now()), 32'(C_RST));
        do_reset();

        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            apply(vecs[i]);
            #1;
            check($sformatf("vec%0d fwda", i), 32'(bus.fwda), 32'(vecs[i].fwda));
            check($sformatf("vec%0d fwdb", i), 32'(bus.fwdb), 32'(vecs[i].fwdb));
            check($sformatf("vec%0d ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
        end

        // Load-use beats branch; branch flushes once the hazard clears.
        @(negedge clock);
        apply(vecs[10]);
        #1 check("luh+br ctl", 32'(ctl_now()), 32'(C_LUH));
        @(negedge clock);
        bus.ewreg = 0;
        #1 check("br after luh ctl", 32'(ctl_now()), 32'(C_BR));

        // Memory access acked on the fourth cycle: three stall cycles.
        do_reset();
        @(negedge clock);
        bus.m_memreq = 1;
        #1 check("mwait c0 ctl", 32'(ctl_now()), 32'(C_STALL));
        for (int k = 1; k <= 2; k++) begin
            @(negedge clock);
            #1 check($sformatf("mwait c%0d ctl", k), 32'(ctl_now()), 32'(C_STALL));
        end
        @(negedge clock);
        bus.m_memack = 1;
        #1 check("mwait ack ctl", 32'(ctl_now()), 32'(C_NORM));
        @(negedge clock);
        bus.m_memreq = 0; bus.m_memack = 0;
        #1;
        check("mwait after ctl", 32'(ctl_now()), 32'(C_NORM));
        check("mwait stall_cycles", bus.stall_cycles, 3);

        // Zero-wait access does not stall.
        @(negedge clock);
        bus.m_memreq = 1; bus.m_memack = 1;
        #1 check("zero-wait ctl", 32'(ctl_now()), 32'(C_NORM));
        @(negedge clock);
        bus.m_memreq = 0; bus.m_memack = 0;
        #1 check("zero-wait stall_cycles", bus.stall_cycles, 3);

        // Timeout of 4: fault appears after the fifth stalled edge and is sticky.
        do_reset();
        @(negedge clock);
        bus.m_memreq = 1;
        #1 check("timeout c0 ctl", 32'(ctl_now()), 32'(C_STALL));
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            #1;
            check($sformatf("timeout c%0d fault", k), 32'(bus.mem_fault), 32'(k == 5));
            check($sformatf("timeout c%0d ctl", k), 32'(ctl_now()), 32'(C_STALL));
        end
        bus.m_memack = 1;
        for (int k = 6; k <= 7; k++) begin
            @(negedge clock);
            #1;
            check($sformatf("fault hold c%0d", k), 32'(bus.mem_fault), 1);
            check($sformatf("fault hold c%0d ctl", k), 32'(ctl_now()), 32'(C_STALL));
        end
        check("fault stall_cycles", bus.stall_cycles, 7);
        do_reset();
        check("fault cleared ctl", 32'(ctl_now()), 32'(C_NORM));

        // Reset mid-MWAIT with ack in the same cycle: reset wins, full timeout again.
        @(negedge clock);
        bus.m_memreq = 1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1; bus.m_memack = 1;
        #1 check("mid-wait reset ctl", 32'(ctl_now()), 32'(C_RST));
        @(negedge clock);
        reset = 1'b0; bus.m_memack = 0;
        #1 check("post mid-wait ctl", 32'(ctl_now()), 32'(C_STALL));
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            #1 check($sformatf("re-timeout c%0d fault", k), 32'(bus.mem_fault), 32'(k == 5));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage CPU. It drives the enables and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the ID-stage forwarding selects. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits. A wait FSM with a timeout latches a sticky fault, and a saturating counter records stall cycles.

Parameters:
MEM_TIMEOUT, 255, maximum MWAIT cycles before fault (1..65535)
CNT_W, 32, width of stall-cycle counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
id_rs  in  5  ID-stage source register A
id_rt  in  5  ID-stage source register B
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_branch_taken  in  1  ID resolves a taken branch/jump
ewreg  in  1  EX instruction writes register file
em2reg  in  1  EX instruction is a load
ern  in  5  EX destination register
mwreg  in  1  MEM instruction writes register file
mm2reg  in  1  MEM instruction is a load
mrn  in  5  MEM destination register
m_memreq  in  1  MEM stage holds a valid load/store
m_memack  in  1  data memory completes this cycle
fwda  out  2  operand A select: 00 regfile, 01 EX alu, 10 MEM alu, 11 MEM memory data
fwdb  out  2  operand B select, same encoding
pc_we  out  1  PC write enable
ifid_we  out  1  IF/ID write enable
ifid_flush  out  1  IF/ID loads a nop
idex_bubble  out  1  ID/EX loads zeroed controls
exmem_we  out  1  EX/MEM write enable
memwb_bubble  out  1  MEM/WB loads mwreg=0, mm2reg=0
mem_fault  out  1  sticky memory-timeout fault
stall_cycles  out  CNT_W  saturating count of cycles with pc_we=0

Behaviour:
- Register and clock semantics:
  - All state updates on posedge clock.
  - Control outputs are combinational from inputs and state.
- Reset (reset=1):
  - Next state RUN; wait counter, stall_cycles and mem_fault cleared.
  - While reset is high: pc_we=ifid_we=exmem_we=0, idex_bubble=memwb_bubble=1, ifid_flush=0, fwda=fwdb=00.
- Forwarding, per operand (rs shown; rt identical with id_use_rt):
  - If ewreg & ern!=0 & ern==rs & !em2reg: select 01.
  - Else if mwreg & mrn!=0 & mrn==rs: select 11 when mm2reg, else 10.
  - Else: select 00.
  - If the use flag is 0, the select is 00.
  - An EX-stage load match gives 00; the load-use stall covers it.
- Load-use hazard: luh = ewreg & em2reg & ern!=0 & ((id_use_rs & ern==id_rs) | (id_use_rt & ern==id_rt)).
- FSM states: RUN, MWAIT, FAULT.
- RUN:
  - If m_memreq & !m_memack: mstall=1 and next state MWAIT with wait counter=1.
  - Otherwise mstall=0.
  - Zero-wait access (req and ack in the same cycle) stays in RUN with no stall.
- MWAIT:
  - If m_memack: mstall=0, next state RUN, counter cleared.
  - Else if counter==MEM_TIMEOUT: next state FAULT.
  - Else: counter+1, mstall=1.
  - m_memreq dropping in MWAIT is treated as an ack.
- FAULT:
  - mem_fault=1; outputs are held as in mstall.
  - Exits only on reset.
- Output priority (highest first):
  - 1. mstall or FAULT: pc_we=ifid_we=exmem_we=0; idex_bubble=0 (ID/EX held via its own enable = exmem_we); memwb_bubble=1; ifid_flush=0.
  - 2. luh: pc_we=ifid_we=0, idex_bubble=1, exmem_we=1, memwb_bubble=0, ifid_flush=0. The branch is re-evaluated next cycle.
  - 3. id_branch_taken: all enables 1, ifid_flush=1.
  - 4. Otherwise: all enables 1, bubbles 0, ifid_flush=0.
- stall_cycles increments when reset=0 and pc_we=0, and saturates at all-ones.

Decomposition:
- pipe_ctrl_pkg holds:
  - FWD_RF/FWD_EALU/FWD_MALU/FWD_MMO 2-bit constants.
  - State enum {RUN, MWAIT, FAULT}.
- Sub-module pipe_fwd_unit: combinational single-operand forwarding select, instantiated twice (rs, rt).

Test Plan:
- EX add writes r5 (ewreg=1, em2reg=0, ern=5); ID reads rs=5 -> fwda=01, all enables 1.
- MEM load to r7 (mwreg=1, mm2reg=1, mrn=7); ID rt=7 -> fwdb=11. With ern=7, ewreg=1, em2reg=0 -> fwdb=01 (EX priority). With rt=0 -> fwdb=00.
- EX load to r3, ID uses rs=3 together with id_branch_taken=1 -> pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0. Next cycle, with the hazard gone -> ifid_flush=1.
- m_memreq=1 with ack after 3 cycles -> 3 cycles of pc_we=exmem_we=0 and memwb_bubble=1, released in the ack cycle. stall_cycles increases by 3.
- MEM_TIMEOUT=4 with no ack -> FAULT after cycle 5, mem_fault=1 and held. Assert reset one cycle -> RUN, mem_fault=0, stall_cycles=0.
- Reset asserted mid-MWAIT with m_memack=1 in the same cycle -> reset wins; the next cycle is RUN with counter 0.
